// File: rtl/demo_uart_tx_pkg.sv
// Shared definitions for the demo UART transmitter: FSM state encodings and
// the ceil-log2 helper used to size the bit-timer and bit-index counters.
package demo_uart_tx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] ST_DATA  = 2'b10;
    localparam logic [1:0] ST_STOP  = 2'b11;

    // Number of bits needed to hold the values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/demo_uart_tx_baud_div.sv
// Bit-timer for the demo UART: counts 0..DIV-1 and flags the last count, which
// marks a serial bit boundary. Cleared by reset, by CLR and at every boundary.
module demo_baud_div
    import demo_uart_tx_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic C,
    input  logic R,
    input  logic CLR,
    output logic TICK
);

    localparam int               CNT_W    = clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    // NOTE: reset is an ordinary data term of a plain posedge flop, so no set/reset cell is needed.
    always_ff @(posedge C) begin
        if (R || CLR || (count == CNT_LAST)) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign TICK = (count == CNT_LAST);

endmodule

// File: rtl/demo_uart_tx.sv
// Demo UART transmitter: accepts a WIDTH-bit word over a valid/ready handshake
// and shifts it out as start bit, data LSB first, stop bit, each DIV clocks long.
module demo_uart_tx
    import demo_uart_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] D,
    input  logic             V,
    output logic             RDY,
    output logic             TX,
    output logic             BUSY
);

    localparam int               IDX_W    = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [IDX_W-1:0] bit_idx;
    logic             tx_q;
    logic             busy_q;
    logic             tick;
    logic             accept;

    assign RDY        = (state == ST_IDLE) && !R;
    assign accept     = V && RDY;
    assign shreg_next = shreg >> 1;
    assign TX         = tx_q;
    assign BUSY       = busy_q;

    demo_baud_div #(
        .DIV (DIV)
    ) u_baud_div (
        .C    (C),
        .R    (R),
        .CLR  (accept),
        .TICK (tick)
    );

    // NOTE: the shift register is cleared on reset too; it is a handful of flops, not a memory array.
    always_ff @(posedge C) begin
        if (R) begin
            state   <= ST_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shreg  <= D;
                        state  <= ST_START;
                        tx_q   <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state   <= ST_DATA;
                        tx_q    <= shreg[0];
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == IDX_LAST) begin
                            state <= ST_STOP;
                            tx_q  <= 1'b1;
                        end else begin
                            shreg   <= shreg_next;
                            tx_q    <= shreg_next[0];
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    // The line is already high; leaving STOP only drops BUSY.
                    if (tick) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
